// File: rtl/complex_magnitude_peak_if.sv
// Streaming bus for complex_magnitude_peak: complex samples in,
// magnitude plus frame peak results out.
interface complex_magnitude_peak_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 16
);
    logic                   enable;
    logic                   dataInValid;
    logic [DATA_WIDTH-1:0]  dataInRe;
    logic [DATA_WIDTH-1:0]  dataInIm;
    logic                   dataOutValid;
    logic [DATA_WIDTH:0]    dataOut;
    logic [DATA_WIDTH:0]    peakValue;
    logic [INDEX_WIDTH-1:0] peakIndex;
    logic                   frameDone;

    modport master (
        output enable, dataInValid, dataInRe, dataInIm,
        input  dataOutValid, dataOut, peakValue, peakIndex, frameDone
    );

    modport slave (
        input  enable, dataInValid, dataInRe, dataInIm,
        output dataOutValid, dataOut, peakValue, peakIndex, frameDone
    );
endinterface

// File: rtl/complex_magnitude_peak.sv
// Pipelined alpha-max-plus-beta-min magnitude with per-frame peak search.
// Peak tracking is compiled in only when PEAK_DETECT_EN is defined.
module complex_magnitude_peak #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_LENGTH = 33000,
    parameter int INDEX_WIDTH  = 16
) (
    input logic clock,
    input logic reset,
    complex_magnitude_peak_if.slave bus
);

    if (FRAME_LENGTH < 2 || FRAME_LENGTH > 2 ** INDEX_WIDTH) begin : g_bad_cfg
        $error("FRAME_LENGTH does not fit INDEX_WIDTH");
    end

    localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1);

    logic                  v1_q, v2_q, v3_q;
    logic [DATA_WIDTH-1:0] absRe_q, absIm_q, absRe_d, absIm_d;
    logic [DATA_WIDTH-1:0] max_q, min_q, max_d, min_d;
    logic [DATA_WIDTH:0]   mag_q, mag_d, mx, mn;

    // -2^(W-1) negates to 2^(W-1), which is exact as a W-bit unsigned
    always_comb begin
        absRe_d = bus.dataInRe[DATA_WIDTH-1] ? (~bus.dataInRe + ONE_W)
                                             : bus.dataInRe;
        absIm_d = bus.dataInIm[DATA_WIDTH-1] ? (~bus.dataInIm + ONE_W)
                                             : bus.dataInIm;
        max_d   = (absRe_q >= absIm_q) ? absRe_q : absIm_q;
        min_d   = (absRe_q >= absIm_q) ? absIm_q : absRe_q;
        mx      = {1'b0, max_q};
        mn      = {1'b0, min_q};
        mag_d   = mx - (mx >> 4) + (mn >> 1) - (mn >> 5);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            absRe_q <= '0;
            absIm_q <= '0;
            max_q   <= '0;
            min_q   <= '0;
            mag_q   <= '0;
        end else if (bus.enable) begin
            v1_q <= bus.dataInValid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (bus.dataInValid) begin
                absRe_q <= absRe_d;
                absIm_q <= absIm_d;
            end
            if (v1_q) begin
                max_q <= max_d;
                min_q <= min_d;
            end
            if (v2_q) begin
                mag_q <= mag_d;
            end
        end
    end

    assign bus.dataOutValid = v3_q;
    assign bus.dataOut      = mag_q;

`ifdef PEAK_DETECT_EN
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(FRAME_LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_I    = INDEX_WIDTH'(1);

    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0] runIdx_q, runIdx_d;
    logic [INDEX_WIDTH-1:0] pkIdx_q, pkIdx_d;
    logic [DATA_WIDTH:0]    run_q, run_d;
    logic [DATA_WIDTH:0]    pk_q, pk_d;
    logic                   done_q, done_d;
    logic                   take;

    // strict compare keeps the earliest index on ties
    always_comb begin
        take     = (cnt_q == '0) || (mag_q > run_q);
        cnt_d    = cnt_q;
        run_d    = run_q;
        runIdx_d = runIdx_q;
        pk_d     = pk_q;
        pkIdx_d  = pkIdx_q;
        done_d   = 1'b0;
        if (v3_q) begin
            if (take) begin
                run_d    = mag_q;
                runIdx_d = cnt_q;
            end
            if (cnt_q == LAST_IDX) begin
                cnt_d   = '0;
                pk_d    = run_d;
                pkIdx_d = runIdx_d;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE_I;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            run_q    <= '0;
            runIdx_q <= '0;
            pk_q     <= '0;
            pkIdx_q  <= '0;
            done_q   <= 1'b0;
        end else if (bus.enable) begin
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            runIdx_q <= runIdx_d;
            pk_q     <= pk_d;
            pkIdx_q  <= pkIdx_d;
            done_q   <= done_d;
        end
    end

    assign bus.peakValue = pk_q;
    assign bus.peakIndex = pkIdx_q;
    assign bus.frameDone = done_q;
`else
    assign bus.peakValue = '0;
    assign bus.peakIndex = '0;
    assign bus.frameDone = 1'b0;
`endif

endmodule

// File: tb/tb_complex_magnitude_peak.sv
// Directed bench for complex_magnitude_peak with an 8-sample frame;
// peak expectations follow whether PEAK_DETECT_EN is defined.
module tb_complex_magnitude_peak;

`ifdef PEAK_DETECT_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   outq[$];
    int   done_n;
    int   pk_v;
    int   pk_i;

    int re1[8]  = '{3000, -32768, -32768, 100, 0, 32767, -1, -200};
    int im1[8]  = '{4000, 0, -32768, -100, 0, 32767, 2, 7};
    int exp1[8] = '{5157, 30720, 46080, 141, 0, 46080, 2, 191};
    int exp2[8] = '{10, 50, 20, 50, 5, 5, 5, 5};
    int re3[8]  = '{7, 3, 9, 9, 2, 1, 4, 8};

    complex_magnitude_peak_if #(.DATA_WIDTH(16), .INDEX_WIDTH(16)) bus ();

    complex_magnitude_peak #(
        .DATA_WIDTH  (16),
        .FRAME_LENGTH(8),
        .INDEX_WIDTH (16)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observe each output/pulse once, at the edge that consumes it
    always @(posedge clk) begin
        if (!rst && bus.enable) begin
            if (bus.dataOutValid) outq.push_back(int'(bus.dataOut));
            if (bus.frameDone) begin
                done_n++;
                pk_v = int'(bus.peakValue);
                pk_i = int'(bus.peakIndex);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic v,
                        input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        bus.enable      = en;
        bus.dataInValid = v;
        bus.dataInRe    = r[15:0];
        bus.dataInIm    = i[15:0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"},  32'(bus.dataOut), 0);
        check({tag, "_dval"},  32'(bus.dataOutValid), 0);
        check({tag, "_pkv"},   32'(bus.peakValue), 0);
        check({tag, "_pki"},   32'(bus.peakIndex), 0);
        check({tag, "_done"},  32'(bus.frameDone), 0);
    endtask

    task automatic check_frame(input string tag, input int exp[8],
                               input int epv, input int epi);
        check({tag, "_count"}, outq.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_out%0d", tag, k),
                  (k < outq.size()) ? outq[k] : -1, exp[k]);
        end
        check({tag, "_done_pulses"}, done_n, PK ? 1 : 0);
        check({tag, "_pkv"}, 32'(bus.peakValue), PK ? epv : 0);
        check({tag, "_pki"}, 32'(bus.peakIndex), PK ? epi : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        outq.delete();
        done_n = 0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        done_n   = 0;
        pk_v     = 0;
        pk_i     = 0;
        rst      = 1'b1;
        bus.enable      = 1'b1;
        bus.dataInValid = 1'b0;
        bus.dataInRe    = '0;
        bus.dataInIm    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // latency: exactly three edges from sample to output
        step(1'b1, 1'b1, 3000, 4000);
        check("lat_e1", 32'(bus.dataOutValid), 0);
        step(1'b1, 1'b0, 0, 0);
        check("lat_e2", 32'(bus.dataOutValid), 0);
        step(1'b1, 1'b0, 0, 0);
        check("lat_e3", 32'(bus.dataOutValid), 1);
        check("lat_val", 32'(bus.dataOut), 5157);
        step(1'b1, 1'b0, 0, 0);
        check("lat_e4", 32'(bus.dataOutValid), 0);
        do_reset();

        // frame 1: extremes, no wrap, tie keeps index 2
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, re1[k], im1[k]);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        check_frame("f1", exp1, 46080, 2);
        check("f1_cap_pkv", pk_v, PK ? 46080 : 0);

        // frame 2: valid gaps and enable low for 5 cycles
        outq.delete();
        done_n = 0;
        step(1'b1, 1'b1, 10, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 53, 0);
        step(1'b1, 1'b1, 21, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b1, 53, 0);
        repeat (5) step(1'b0, 1'b1, 999, 999);
        repeat (4) step(1'b1, 1'b1, 5, 0);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        check_frame("f2", exp2, 50, 1);
        check("f2_cap_pki", pk_i, PK ? 1 : 0);

        // partial frame of large values, then reset mid-frame
        outq.delete();
        done_n = 0;
        repeat (4) step(1'b1, 1'b1, 1000, 0);
        check("part_dval", 32'(bus.dataOutValid), 1);
        check("part_dout", 32'(bus.dataOut), 938);
        check("part_hold", 32'(bus.peakValue), PK ? 50 : 0);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        do_reset();

        // frame 3 after reset: fresh index 0
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, re3[k], 0);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        check_frame("f3", re3, 9, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
